fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the cacheline buffer. It generates sequential fetch PCs and issues one-word read requests on the buffer's upstream port, holding each request until `mem_resp`. Returned instructions go into a small FIFO for decode. Branch/jump redirects flush the FIFO; a response to a request already in flight when the redirect arrives is discarded.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential one-word reads to the cacheline buffer and
// queues returned {pc, inst} pairs for decode. Redirects flush the queue.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     stale_q, stale_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic        req_active;
  logic        enq;
  logic        deq;
  logic        flush;
  logic [31:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~32'h3;

  // Outputs depend only on registered state, count and rst_n.
  always_comb begin
    req_active = rst_n && ((state_q == StDrain) || (count_q < DepthCnt));
    mem_rmask  = req_active ? 4'hF : 4'h0;
    mem_addr   = (state_q == StDrain) ? stale_q : pc_q;
    deq_valid  = rst_n && (count_q != '0);
    deq_inst   = inst_mem[head_q];
    deq_pc     = pc_mem[head_q];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    enq     = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc_aligned;
          // An in-flight miss must complete at its original address before refetching.
          if (req_active && !mem_resp) begin
            state_d = StDrain;
            stale_d = pc_q;
          end
        end else if (req_active && mem_resp) begin
          enq  = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      StDrain: begin
        if (mem_resp) begin
          state_d = StFetch;
        end
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc_aligned;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    deq = deq_valid && deq_ready && !flush;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(deq);
      tail_d  = tail_q + PtrW'(enq);
      count_d = count_q + (PtrW + 1)'(enq) - (PtrW + 1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      stale_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, checked against a
// queue-based reference model with a scoreboard popped by a dequeue monitor.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5A5A5;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_rmask     (mem_rmask),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_inst      (deq_inst),
    .deq_pc        (deq_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  int     checks = 0;
  int     errors = 0;
  entry_t sb[$];
  entry_t mon_e;

  // Reference model: next fetch PC, whether a discarded response is pending, and its address.
  logic [31:0] m_pc;
  logic [31:0] m_stale;
  bit          m_drain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called mid-cycle with outputs settled: check, drive inputs for the next edge, update model.
  task automatic step(input bit resp, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit active;
    active = m_drain || (sb.size() < DEPTH);
    chk("mem_rmask", {28'b0, mem_rmask}, active ? 32'hF : 32'h0);
    chk("mem_addr", mem_addr, m_drain ? m_stale : m_pc);
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("head_pc", deq_pc, sb[0].pc);
      chk("head_inst", deq_inst, sb[0].inst);
    end

    mem_resp       = resp && (mem_rmask == 4'hF);
    mem_rdata      = mem_addr ^ XOR_KEY;
    redirect_valid = redir;
    redirect_pc    = rpc;
    deq_ready      = rdy;

    if (!m_drain) begin
      if (redir) begin
        sb.delete();
        if (active && !mem_resp) begin
          m_drain = 1'b1;
          m_stale = m_pc;
        end
        m_pc = rpc & ~32'h3;
      end else if (active && mem_resp) begin
        sb.push_back('{pc: m_pc, inst: m_pc ^ XOR_KEY});
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (mem_resp) m_drain = 1'b0;
      if (redir) begin
        sb.delete();
        m_pc = rpc & ~32'h3;
      end
    end

    @(posedge clk);
    #2;
  endtask

  // Flush wins over a same-cycle dequeue, so no pop when a redirect is driven.
  always @(negedge clk) begin
    if (rst_n && deq_valid && deq_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected actual=%h required=none", deq_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("deq_pc", deq_pc, mon_e.pc);
        chk("deq_inst", deq_inst, mon_e.inst);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    mem_rdata      = '0;
    mem_resp       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_ready      = 1'b0;
    m_pc           = RESET_PC;
    m_stale        = '0;
    m_drain        = 1'b0;

    @(posedge clk);
    #2;
    chk("rst_rmask", {28'b0, mem_rmask}, 32'h0);
    chk("rst_deq_valid", {31'b0, deq_valid}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_addr", mem_addr, RESET_PC);

    // Hit streaming at one instruction per cycle.
    repeat (8) step(1'b1, 1'b0, '0, 1'b1);

    // Fill to full under backpressure, then a single dequeue pulse.
    repeat (6) step(1'b1, 1'b0, '0, 1'b0);
    chk("full_rmask", {28'b0, mem_rmask}, 32'h0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("refill_rmask", {28'b0, mem_rmask}, 32'hF);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect during a miss: stale address held until its response.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h1eceb100, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("post_drain_addr", mem_addr, 32'h1eceb100);
    repeat (3) step(1'b1, 1'b0, '0, 1'b1);

    // Redirect coincident with a response.
    step(1'b1, 1'b1, 32'h1eceb200, 1'b1);
    chk("coincident_addr", mem_addr, 32'h1eceb200);
    chk("coincident_empty", {31'b0, deq_valid}, 32'h0);

    // Alignment and wrap.
    step(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    chk("wrap_align", mem_addr, 32'hFFFFFFFC);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("wrap_zero", mem_addr, 32'h0);
    repeat (3) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic.
    repeat (3000) begin
      step(($urandom % 3) != 0, ($urandom % 24) == 0, $urandom, ($urandom % 10) < 6);
    end
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
